// File: rtl/logic_gate_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
//
// Purpose:
//   Shared definitions for the logic gate unit: the 3-bit operation codes
//   and the single-bit evaluation function used to build the datapath.
//
// Contents:
//   gate_op_t   3-bit operation select type
//   OP_AND..OP_PASS  operation encodings
//   gate_eval   evaluates one operation on one bit of A and B
// ---------------------------------------------------------------------------
package logic_gate_pkg;

    typedef logic [2:0] gate_op_t;

    localparam gate_op_t OP_AND  = 3'b000;
    localparam gate_op_t OP_OR   = 3'b001;
    localparam gate_op_t OP_XOR  = 3'b010;
    localparam gate_op_t OP_NAND = 3'b011;
    localparam gate_op_t OP_NOR  = 3'b100;
    localparam gate_op_t OP_XNOR = 3'b101;
    localparam gate_op_t OP_ANDN = 3'b110;
    localparam gate_op_t OP_PASS = 3'b111;

    // Every supported function is bitwise, so a single-bit evaluator applied
    // per bit position serves any word width without truncation concerns.
    function automatic logic gate_eval(input gate_op_t op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_ANDN: return a & ~b;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/logic_gate_unit_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
//
// Purpose:
//   Generic single-entry valid/ready register slice. Accepts a beat whenever
//   it is empty or its current beat is leaving in the same cycle, so a chain
//   of these sustains one beat per cycle with no bubbles.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset, empties the slice
//   inValid_i   upstream beat valid
//   inReady_o   slice can take a beat this cycle
//   inData_i    upstream payload
//   outValid_o  slice holds a beat
//   outReady_i  downstream takes the held beat
//   outData_o   held payload, stable while stalled
// ---------------------------------------------------------------------------
module pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inValid_i,
    output logic          inReady_o,
    input  logic [DW-1:0] inData_i,
    output logic          outValid_o,
    input  logic          outReady_i,
    output logic [DW-1:0] outData_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Ready depends only on local state and the downstream ready, never on
    // inValid_i, so no combinational valid-to-ready loop can form.
    assign inReady_o  = !valid_q || outReady_i;
    assign outValid_o = valid_q;
    assign outData_o  = data_q;

    // Payload only changes on an accepted beat, which keeps the output
    // stable for as long as downstream stalls.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (inValid_i && inReady_o) begin
            valid_d = 1'b1;
            data_d  = inData_i;
        end else if (outReady_i) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/logic_gate_unit.sv
// ---------------------------------------------------------------------------
// logic_gate_unit
//
// Purpose:
//   Two-stage pipelined bitwise logic unit. Stage 1 captures op/A/B, stage 2
//   captures the result word and its flags. Valid/ready on both sides, one
//   beat per cycle, two cycles of latency, plus a count of results delivered.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    input beat valid
//   in_ready    unit can accept an input beat
//   in_op       operation select (see logic_gate_pkg)
//   in_a        operand A
//   in_b        operand B
//   out_valid   result beat valid
//   out_ready   downstream accepts the result
//   out_o       result word
//   out_zero    out_o is all zeros
//   out_ones    out_o is all ones
//   out_parity  XOR reduction of out_o
//   done_cnt    output handshakes since reset, wraps silently
// ---------------------------------------------------------------------------
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_o,
    output logic                 out_zero,
    output logic                 out_ones,
    output logic                 out_parity,
    output logic [CNT_WIDTH-1:0] done_cnt
);

    localparam int S1_W = 3 + 2 * WIDTH;
    localparam int S2_W = WIDTH + 3;

    logic [S1_W-1:0]      s1In;
    logic [S1_W-1:0]      s1Out;
    logic                 s1Valid;
    logic                 s2Ready;
    gate_op_t             s1Op;
    logic [WIDTH-1:0]     s1A;
    logic [WIDTH-1:0]     s1B;
    logic [WIDTH-1:0]     result;
    logic                 resZero;
    logic                 resOnes;
    logic                 resParity;
    logic [S2_W-1:0]      s2In;
    logic [S2_W-1:0]      s2Out;
    logic [CNT_WIDTH-1:0] doneCnt_q;
    logic [CNT_WIDTH-1:0] doneCnt_d;

    assign s1In = {in_op, in_a, in_b};

    pipe_reg #(.DW(S1_W)) stage1 (
        .clk        (clk),
        .rst        (rst),
        .inValid_i  (in_valid),
        .inReady_o  (in_ready),
        .inData_i   (s1In),
        .outValid_o (s1Valid),
        .outReady_i (s2Ready),
        .outData_o  (s1Out)
    );

    assign {s1Op, s1A, s1B} = s1Out;

    // Apply the selected function bit by bit on the stage-1 operands.
    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = gate_eval(s1Op, s1A[i], s1B[i]);
        end
    end

    // Flags are computed before stage 2 so they are registered alongside
    // the word and stay consistent with it under backpressure.
    assign resZero   = ~|result;
    assign resOnes   = &result;
    assign resParity = ^result;

    assign s2In = {resParity, resOnes, resZero, result};

    pipe_reg #(.DW(S2_W)) stage2 (
        .clk        (clk),
        .rst        (rst),
        .inValid_i  (s1Valid),
        .inReady_o  (s2Ready),
        .inData_i   (s2In),
        .outValid_o (out_valid),
        .outReady_i (out_ready),
        .outData_o  (s2Out)
    );

    assign {out_parity, out_ones, out_zero, out_o} = s2Out;

    // Completed-transaction counter; natural binary overflow gives the wrap.
    always_comb begin
        doneCnt_d = doneCnt_q;
        if (out_valid && out_ready) begin
            doneCnt_d = doneCnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            doneCnt_q <= '0;
        end else begin
            doneCnt_q <= doneCnt_d;
        end
    end

    assign done_cnt = doneCnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// ---------------------------------------------------------------------------
// tb_logic_gate_unit
//
// Purpose:
//   Directed self-checking bench for logic_gate_unit. A table of hand-computed
//   vectors drives streaming checks; backpressure, mid-flight reset and
//   counter wrap are covered by hand-written sequences. A second instance
//   with a 2-bit counter shares the stimulus for the wrap check.
// ---------------------------------------------------------------------------
module tb_logic_gate_unit;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expOut;
        logic       expZero;
        logic       expOnes;
        logic       expParity;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [2:0]  inOp;
    logic [7:0]  inA;
    logic [7:0]  inB;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outO;
    logic        outZero;
    logic        outOnes;
    logic        outParity;
    logic [15:0] doneCnt;

    logic        inReady2;
    logic        outValid2;
    logic [7:0]  outO2;
    logic        outZero2;
    logic        outOnes2;
    logic        outParity2;
    logic [1:0]  doneCnt2;

    vec_t vecs[14];
    int   compared;
    int   mismatched;

    logic_gate_unit #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_op      (inOp),
        .in_a       (inA),
        .in_b       (inB),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_o      (outO),
        .out_zero   (outZero),
        .out_ones   (outOnes),
        .out_parity (outParity),
        .done_cnt   (doneCnt)
    );

    logic_gate_unit #(.WIDTH(8), .CNT_WIDTH(2)) dutWrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady2),
        .in_op      (inOp),
        .in_a       (inA),
        .in_b       (inB),
        .out_valid  (outValid2),
        .out_ready  (outReady),
        .out_o      (outO2),
        .out_zero   (outZero2),
        .out_ones   (outOnes2),
        .out_parity (outParity2),
        .done_cnt   (doneCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveVec(input vec_t v);
        inValid = 1'b1;
        inOp    = v.op;
        inA     = v.a;
        inB     = v.b;
    endtask

    // Idle cycles carry junk operands that must be ignored.
    task automatic driveIdle();
        inValid = 1'b0;
        inOp    = 3'b011;
        inA     = 8'h5A;
        inB     = 8'hC3;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        driveIdle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Streams n table entries back to back with out_ready high and checks
    // each result appears exactly two cycles after its handshake, gap-free.
    task automatic applyStimulus(input int start, input int n);
        outReady = 1'b1;
        for (int t = 0; t < n + 2; t++) begin
            @(posedge clk);
            #1;
            if (t < n) driveVec(vecs[start + t]);
            else       driveIdle();
            #1;
            if (t == 1) checkOutput("latency not early", {31'd0, outValid}, 32'd0);
            if (t >= 2) begin
                checkOutput("stream valid",  {31'd0, outValid}, 32'd1);
                checkOutput("stream out",    {24'd0, outO}, {24'd0, vecs[start + t - 2].expOut});
                checkOutput("stream zero",   {31'd0, outZero}, {31'd0, vecs[start + t - 2].expZero});
                checkOutput("stream ones",   {31'd0, outOnes}, {31'd0, vecs[start + t - 2].expOnes});
                checkOutput("stream parity", {31'd0, outParity}, {31'd0, vecs[start + t - 2].expParity});
            end
        end
        @(posedge clk);
        #1;
        checkOutput("stream drained", {31'd0, outValid}, 32'd0);
        checkOutput("stream done_cnt", {16'd0, doneCnt}, n);
    endtask

    initial begin
        int   got;
        int   hs;
        logic accept;
        logic emit;
        logic hsNow;
        int   wrapSeq[5];

        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        outReady   = 1'b1;
        driveIdle();

        //                op      a      b      out    z     o     p
        vecs[0]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b100, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 8'hA5, 8'h0F, 8'hA0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b111, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 8'h77, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b111, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b001, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'b011, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};

        wrapSeq = '{1, 2, 3, 0, 1};

        // Reset state.
        applyReset();
        #1;
        checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset in_ready",  {31'd0, inReady}, 32'd1);
        checkOutput("reset out_o",     {24'd0, outO}, 32'd0);
        checkOutput("reset flags",     {29'd0, outZero, outOnes, outParity}, 32'd0);
        checkOutput("reset done_cnt",  {16'd0, doneCnt}, 32'd0);

        // Single AND beat: latency and first count.
        applyStimulus(0, 1);

        // All eight ops back to back.
        applyReset();
        applyStimulus(1, 8);

        // Flag corner cases.
        applyReset();
        applyStimulus(9, 5);

        // Backpressure: two beats fill the unit, third waits.
        applyReset();
        outReady = 1'b0;
        driveVec(vecs[0]);
        #1;
        checkOutput("bp ready empty", {31'd0, inReady}, 32'd1);
        @(posedge clk);
        #1;
        driveVec(vecs[1]);
        #1;
        checkOutput("bp ready one", {31'd0, inReady}, 32'd1);
        @(posedge clk);
        #1;
        driveVec(vecs[2]);
        #1;
        checkOutput("bp ready full", {31'd0, inReady}, 32'd0);
        checkOutput("bp valid full", {31'd0, outValid}, 32'd1);
        checkOutput("bp first out",  {24'd0, outO}, {24'd0, vecs[0].expOut});
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            checkOutput("bp hold ready", {31'd0, inReady}, 32'd0);
            checkOutput("bp hold out",   {24'd0, outO}, {24'd0, vecs[0].expOut});
            checkOutput("bp hold valid", {31'd0, outValid}, 32'd1);
        end
        outReady = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            #1;
            accept = inValid && inReady;
            emit   = outValid;
            if (emit) begin
                checkOutput("bp drain order", {24'd0, outO}, {24'd0, vecs[got].expOut});
                got++;
            end
            @(posedge clk);
            #1;
            if (accept) inValid = 1'b0;
        end
        checkOutput("bp drain count", got, 32'd3);
        checkOutput("bp done_cnt", {16'd0, doneCnt}, 32'd3);

        // Reset with two beats in flight.
        applyReset();
        outReady = 1'b0;
        driveVec(vecs[2]);
        @(posedge clk);
        #1;
        driveVec(vecs[3]);
        @(posedge clk);
        #1;
        driveIdle();
        #1;
        checkOutput("midrst before", {31'd0, outValid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("midrst done_cnt",  {16'd0, doneCnt}, 32'd0);
        checkOutput("midrst out_o",     {24'd0, outO}, 32'd0);
        outReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            checkOutput("midrst no stale", {31'd0, outValid}, 32'd0);
        end
        checkOutput("midrst cnt after", {16'd0, doneCnt}, 32'd0);

        // Counter wrap on the 2-bit instance.
        applyReset();
        outReady = 1'b1;
        hs = 0;
        for (int t = 0; t < 14 && hs < 5; t++) begin
            if (t < 5) driveVec(vecs[1 + t]);
            else       driveIdle();
            #1;
            hsNow = outValid2 && outReady;
            if (hsNow) checkOutput("wrap out", {24'd0, outO2}, {24'd0, vecs[1 + hs].expOut});
            @(posedge clk);
            #1;
            if (hsNow) begin
                checkOutput("wrap done_cnt", {30'd0, doneCnt2}, wrapSeq[hs]);
                hs++;
            end
        end
        checkOutput("wrap handshakes", hs, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
